sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/fifo_pkg.sv | 15 +
 rtl/sync_fifo_ram.sv | 27 ++
 rtl/sync_fifo.sv | 110 +++++++++++
 tb/tb_sync_fifo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO defaults: data width, address bits and fill-level thresholds.
// Reused by every FIFO block so defaults stay consistent across the codebase.
package fifo_pkg;

  localparam int unsigned FifoWidth    = 8;
  localparam int unsigned FifoAddLines = 5;
  localparam int unsigned FifoAeLevel  = 2;
  // almost_full default sits this many words below the full depth
  localparam int unsigned FifoAfMargin = 2;

  function automatic int unsigned fifo_depth(input int unsigned add_lines);
    return 32'd1 << add_lines;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo: one synchronous write port, one
// asynchronous read port, no reset (contents undefined after power-up).
module sync_fifo_ram #(
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = 5
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, level flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = FifoWidth,
  parameter int unsigned ADD_LINES = FifoAddLines,
  parameter int unsigned AF_LEVEL  = fifo_depth(ADD_LINES) - FifoAfMargin,
  parameter int unsigned AE_LEVEL  = FifoAeLevel
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 wr_en,
  input  logic                 read_en,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     data_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADD_LINES:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int unsigned PtrW = ADD_LINES + 1;
  localparam logic [ADD_LINES:0] DepthCnt = PtrW'(fifo_depth(ADD_LINES));
  localparam logic [ADD_LINES:0] AfCnt    = PtrW'(AF_LEVEL);
  localparam logic [ADD_LINES:0] AeCnt    = PtrW'(AE_LEVEL);

  logic [ADD_LINES:0] wr_ptr_q, wr_ptr_d;
  logic [ADD_LINES:0] rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               wr_acc, rd_acc;
  logic [WIDTH-1:0]   rd_data;

  // Flags come only from registered pointers, never from this cycle's requests.
  always_comb begin
    count        = wr_ptr_q - rd_ptr_q;
    full         = (count == DepthCnt);
    empty        = (count == '0);
    almost_full  = (count >= AfCnt);
    almost_empty = (count <= AeCnt);
  end

  always_comb begin
    wr_acc      = wr_en && !full;
    rd_acc      = read_en && !empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    // A fresh error in the clearing cycle keeps the flag set
    overflow_d  = (overflow_q && !err_clr) || (wr_en && full);
    underflow_d = (underflow_q && !err_clr) || (read_en && empty);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  sync_fifo_ram #(
    .Width (WIDTH),
    .AddrW (ADD_LINES)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADD_LINES-1:0]),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q[ADD_LINES-1:0]),
    .rdata_o (rd_data)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = rd_data;
`else
  logic [WIDTH-1:0] data_out_q, data_out_d;

  always_comb begin
    data_out_d = data_out_q;
    if (rd_acc) data_out_d = rd_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (WIDTH=8, ADD_LINES=4, AF=14, AE=2):
// a vector table for single-cycle behaviour plus sequences for fill, drain, wrap and reset.
module tb_sync_fifo;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] data_in;
  logic       wr_en, read_en, err_clr;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  always #5 clk = ~clk;

  sync_fifo #(
    .WIDTH     (8),
    .ADD_LINES (4),
    .AF_LEVEL  (14),
    .AE_LEVEL  (2)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .data_in      (data_in),
    .wr_en        (wr_en),
    .read_en      (read_en),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] sb_q[$];
  logic       ovf_m, unf_m;
  logic [7:0] last_m;

  typedef struct {
    logic       w, r, clr;
    logic [7:0] d;
    logic [4:0] cnt;
    logic       em, ae, unf;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_status();
    int n;
    n = sb_q.size();
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == D));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= 14));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    chk("underflow", 32'(underflow), 32'(unf_m));
  endtask

  // One clock of stimulus; the queue holds what the DUT must return, in order.
  task automatic cycle(input logic w, input logic r, input logic c, input logic [7:0] d);
    logic       full_m, empty_m, wacc, racc;
    logic [7:0] popped;
    full_m  = (sb_q.size() == D);
    empty_m = (sb_q.size() == 0);
    wacc    = w && !full_m;
    racc    = r && !empty_m;
    wr_en   = w;
    read_en = r;
    err_clr = c;
    data_in = d;
`ifdef SYNC_FIFO_FWFT_EN
    if (!empty_m) chk("fwft_data", 32'(data_out), 32'(sb_q[0]));
`endif
    @(posedge clk);
    #1;
    popped = 8'h00;
    if (racc) popped = sb_q.pop_front();
    if (wacc) sb_q.push_back(d);
    ovf_m = (ovf_m && !c) || (w && full_m);
    unf_m = (unf_m && !c) || (r && empty_m);
`ifndef SYNC_FIFO_FWFT_EN
    if (racc) begin
      last_m = popped;
      chk("rd_data", 32'(data_out), 32'(last_m));
    end else begin
      chk("hold_data", 32'(data_out), 32'(last_m));
    end
`endif
    wr_en   = 1'b0;
    read_en = 1'b0;
    err_clr = 1'b0;
    chk_status();
  endtask

  // Asserts reset away from any clock edge and checks it acts immediately.
  task automatic do_reset();
    #2;
    resetn = 1'b0;
    #1;
    sb_q.delete();
    ovf_m  = 1'b0;
    unf_m  = 1'b0;
    last_m = 8'h00;
    chk_status();
`ifndef SYNC_FIFO_FWFT_EN
    chk("reset_data_out", 32'(data_out), 32'h0);
`endif
    wr_en   = 1'b0;
    read_en = 1'b0;
    err_clr = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //               w     r     clr   d      cnt   em    ae    unf   dout
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'hA0, 5'd1, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'hA1, 5'd2, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'hA2, 5'd3, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'hA3, 5'd3, 1'b0, 1'b0, 1'b0, 8'hA0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd2, 1'b0, 1'b1, 1'b0, 8'hA1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0, 1'b1, 1'b0, 8'hA2};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b1, 1'b0, 8'hA3};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b1, 1'b1, 8'hA3};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b1, 1'b0, 8'hA3};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h00, 5'd0, 1'b1, 1'b1, 1'b1, 8'hA3};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'hB0, 5'd1, 1'b0, 1'b1, 1'b0, 8'hA3};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 8'hB1, 5'd1, 1'b0, 1'b1, 1'b0, 8'hB0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b1, 1'b0, 8'hB1};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 8'hC0, 5'd1, 1'b0, 1'b1, 1'b1, 8'hB1};

    resetn  = 1'b1;
    wr_en   = 1'b0;
    read_en = 1'b0;
    err_clr = 1'b0;
    data_in = 8'h00;
    do_reset();

    foreach (vecs[i]) begin
      cycle(vecs[i].w, vecs[i].r, vecs[i].clr, vecs[i].d);
      chk("vec_count", 32'(count), 32'(vecs[i].cnt));
      chk("vec_empty", 32'(empty), 32'(vecs[i].em));
      chk("vec_almost_empty", 32'(almost_empty), 32'(vecs[i].ae));
      chk("vec_underflow", 32'(underflow), 32'(vecs[i].unf));
`ifndef SYNC_FIFO_FWFT_EN
      chk("vec_data_out", 32'(data_out), 32'(vecs[i].dout));
`endif
    end

    // Fill to full, then one write too many.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 8'(i));
    chk("fill_full", 32'(full), 32'h1);
    cycle(1'b1, 1'b0, 1'b0, 8'hAA);
    chk("fill_overflow", 32'(overflow), 32'h1);

    // Drain in order, then one read too many.
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("drain_underflow", 32'(underflow), 32'h1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("drain_hold_0f", 32'(data_out), 32'h0F);
`endif
    cycle(1'b0, 1'b0, 1'b1, 8'h00);

    // Steady state at count 8 across two pointer wraps.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
    chk("stream_count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

    // Full with both requests: read wins, write rejected.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
    cycle(1'b1, 1'b1, 1'b0, 8'h55);
    chk("both_full_count", 32'(count), 32'd15);
    chk("both_full_overflow", 32'(overflow), 32'h1);

    // Reset mid-burst at count 5 with a write in flight.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("pre_reset_count", 32'(count), 32'd5);
    wr_en   = 1'b1;
    data_in = 8'hEE;
    do_reset();
    chk("post_reset_overflow", 32'(overflow), 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 8'h77);
    cycle(1'b1, 1'b0, 1'b0, 8'h78);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
    chk("first_after_reset", 32'(data_out), 32'h77);
`endif

    // Sticky overflow, then cleared by err_clr.
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
    cycle(1'b1, 1'b0, 1'b0, 8'hDD);
    chk("set_overflow", 32'(overflow), 32'h1);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    chk("clr_overflow", 32'(overflow), 32'h0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
